// File: rtl/fft_iter_core.sv
// Iterative in-place radix-2 DIT FFT: loads N samples in bit-reversed order,
// runs one butterfly per cycle with 1/2 scaling per stage, then streams X[k]/N.
module fft_iter_core #(
    parameter int LOG2N = 3,
    parameter int DW    = 16,
    parameter int TW    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [DW-1:0]    in_re,
    input  logic signed [DW-1:0]    in_im,
    input  logic                    inv,
    output logic [LOG2N-2:0]        tw_addr,
    input  logic signed [TW-1:0]    tw_re,
    input  logic signed [TW-1:0]    tw_im,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [DW-1:0]    out_re,
    output logic signed [DW-1:0]    out_im,
    output logic [LOG2N-1:0]        out_idx,
    output logic                    out_last,
    output logic                    busy
);

    localparam int N  = 1 << LOG2N;
    localparam int SW = $clog2(LOG2N);
    localparam int PW = DW + TW + 2;
    localparam logic [LOG2N-1:0] IDX_LAST = {LOG2N{1'b1}};
    localparam logic [LOG2N-2:0] BF_LAST  = {(LOG2N-1){1'b1}};
    localparam logic [SW-1:0]    STG_LAST = SW'(LOG2N-1);
    localparam logic [LOG2N-1:0] ONE_IDX  = {{(LOG2N-1){1'b0}}, 1'b1};
    localparam logic signed [DW+1:0] SAT_MAX = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [DW+1:0] SAT_MIN = {3'b111, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_CALC   = 2'd1,
        ST_UNLOAD = 2'd2
    } state_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    // Halve with floor, then clamp into the DW-bit signed range.
    function automatic logic signed [DW-1:0] sat_half(input logic signed [DW+1:0] v);
        logic signed [DW+1:0] sh;
        sh = v >>> 1;
        if (sh > SAT_MAX) begin
            return DW'(SAT_MAX);
        end else if (sh < SAT_MIN) begin
            return DW'(SAT_MIN);
        end else begin
            return DW'(sh);
        end
    endfunction

    state_t                 state_q, state_d;
    logic [LOG2N-1:0]       load_cnt_q, load_cnt_d;
    logic                   inv_q, inv_d;
    logic [SW-1:0]          stage_q, stage_d;
    logic [LOG2N-2:0]       bfly_q, bfly_d;
    logic [LOG2N-1:0]       out_idx_q, out_idx_d;
    logic signed [DW-1:0]   mem_re_q [N];
    logic signed [DW-1:0]   mem_im_q [N];

    logic [LOG2N-1:0]       bf_w_s, h_s, j_s, top_s, bot_s, k_s;
    logic signed [DW-1:0]   a_re_s, a_im_s, b_re_s, b_im_s;
    logic signed [TW:0]     w_im_s;
    logic signed [PW-1:0]   pr_re_s, pr_im_s;
    logic signed [DW+1:0]   t_re_s, t_im_s;
    logic signed [DW-1:0]   top_re_s, top_im_s, bot_re_s, bot_im_s;

    // Butterfly addressing and arithmetic for the current CALC step.
    always_comb begin
        bf_w_s = {1'b0, bfly_q};
        h_s    = ONE_IDX << stage_q;
        j_s    = bf_w_s & (h_s - ONE_IDX);
        top_s  = ((bf_w_s & ~(h_s - ONE_IDX)) << 1) | j_s;
        bot_s  = top_s | h_s;
        k_s    = j_s << (STG_LAST - stage_q);
        a_re_s = mem_re_q[top_s];
        a_im_s = mem_im_q[top_s];
        b_re_s = mem_re_q[bot_s];
        b_im_s = mem_im_q[bot_s];
        w_im_s = inv_q ? -((TW+1)'(tw_im)) : (TW+1)'(tw_im);
        pr_re_s = PW'(b_re_s) * PW'(tw_re) - PW'(b_im_s) * PW'(w_im_s);
        pr_im_s = PW'(b_re_s) * PW'(w_im_s) + PW'(b_im_s) * PW'(tw_re);
        if (j_s == {LOG2N{1'b0}}) begin
            t_re_s = (DW+2)'(b_re_s);
            t_im_s = (DW+2)'(b_im_s);
        end else begin
            t_re_s = (DW+2)'(pr_re_s >>> (TW-1));
            t_im_s = (DW+2)'(pr_im_s >>> (TW-1));
        end
        top_re_s = sat_half((DW+2)'(a_re_s) + t_re_s);
        top_im_s = sat_half((DW+2)'(a_im_s) + t_im_s);
        bot_re_s = sat_half((DW+2)'(a_re_s) - t_re_s);
        bot_im_s = sat_half((DW+2)'(a_im_s) - t_im_s);
    end

    // Next-state logic for the LOAD / CALC / UNLOAD sequencer.
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        inv_d      = inv_q;
        stage_d    = stage_q;
        bfly_d     = bfly_q;
        out_idx_d  = out_idx_q;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    load_cnt_d = load_cnt_q + ONE_IDX;
                    if (load_cnt_q == {LOG2N{1'b0}}) begin
                        inv_d = inv;
                    end else begin
                        inv_d = inv_q;
                    end
                    if (load_cnt_q == IDX_LAST) begin
                        state_d = ST_CALC;
                        stage_d = {SW{1'b0}};
                        bfly_d  = {(LOG2N-1){1'b0}};
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    load_cnt_d = load_cnt_q;
                end
            end
            ST_CALC: begin
                bfly_d = bfly_q + {{(LOG2N-2){1'b0}}, 1'b1};
                if (bfly_q == BF_LAST) begin
                    if (stage_q == STG_LAST) begin
                        state_d   = ST_UNLOAD;
                        out_idx_d = {LOG2N{1'b0}};
                    end else begin
                        stage_d = stage_q + {{(SW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    stage_d = stage_q;
                end
            end
            ST_UNLOAD: begin
                if (out_ready) begin
                    out_idx_d = out_idx_q + ONE_IDX;
                    if (out_idx_q == IDX_LAST) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_UNLOAD;
                    end
                end else begin
                    out_idx_d = out_idx_q;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            load_cnt_q <= {LOG2N{1'b0}};
            inv_q      <= 1'b0;
            stage_q    <= {SW{1'b0}};
            bfly_q     <= {(LOG2N-1){1'b0}};
            out_idx_q  <= {LOG2N{1'b0}};
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            inv_q      <= inv_d;
            stage_q    <= stage_d;
            bfly_q     <= bfly_d;
            out_idx_q  <= out_idx_d;
        end
    end

    // Sample array: bit-reversed writes on load, in-place butterfly writeback in CALC.
    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD && in_valid) begin
            mem_re_q[bitrev(load_cnt_q)] <= in_re;
            mem_im_q[bitrev(load_cnt_q)] <= in_im;
        end else if (state_q == ST_CALC) begin
            mem_re_q[top_s] <= top_re_s;
            mem_im_q[top_s] <= top_im_s;
            mem_re_q[bot_s] <= bot_re_s;
            mem_im_q[bot_s] <= bot_im_s;
        end
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_LOAD);
    assign out_valid = (state_q == ST_UNLOAD);
    assign out_idx   = out_idx_q;
    assign out_last  = (state_q == ST_UNLOAD) && (out_idx_q == IDX_LAST);
    assign out_re    = mem_re_q[out_idx_q];
    assign out_im    = mem_im_q[out_idx_q];
    assign tw_addr   = (state_q == ST_CALC) ? (LOG2N-1)'(k_s) : {(LOG2N-1){1'b0}};

endmodule

// File: tb/tb_fft_iter_core.sv
// Directed bench for fft_iter_core at N=8, DW=16, TW=16 with a rounded twiddle ROM.
`timescale 1ns/1ps
module tb_fft_iter_core;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_re = 16'sd0;
    logic signed [15:0] in_im = 16'sd0;
    logic               inv = 1'b0;
    logic [1:0]         tw_addr;
    logic signed [15:0] tw_re, tw_im;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [15:0] out_re, out_im;
    logic [2:0]         out_idx;
    logic               out_last;
    logic               busy;

    int checks = 0;
    int errors = 0;
    logic signed [15:0] fre [8];
    logic signed [15:0] fim [8];
    logic signed [15:0] ere [8];
    logic signed [15:0] eim [8];
    logic               hold_valid = 1'b0;

    fft_iter_core #(.LOG2N(3), .DW(16), .TW(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im), .inv(inv),
        .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // W(k) = exp(-j*2*pi*k/8), components round(32767*cos), -round(32767*sin)
    always_comb begin
        case (tw_addr)
            2'd0:    begin tw_re = 16'sd32767;  tw_im = 16'sd0;      end
            2'd1:    begin tw_re = 16'sd23170;  tw_im = -16'sd23170; end
            2'd2:    begin tw_re = 16'sd0;      tw_im = -16'sd32767; end
            2'd3:    begin tw_re = -16'sd23170; tw_im = -16'sd23170; end
            default: begin tw_re = 16'sd0;      tw_im = 16'sd0;      end
        endcase
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic inv_b);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_re    = fre[i];
            in_im    = fim[i];
            inv      = (i == 0) ? inv_b : ~inv_b;
            @(posedge clk);
            #1;
        end
        in_valid = hold_valid;
        in_re    = 16'sd0;
        in_im    = 16'sd0;
    endtask

    task automatic wait_out(input string nm);
        int cyc;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({nm, "_latency"}, cyc, 12);
        chk({nm, "_inready_busy"}, in_ready, 0);
    endtask

    task automatic recv_frame(input string nm);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_valid%0d", nm, i), out_valid, 1);
            chk($sformatf("%s_idx%0d", nm, i), out_idx, i);
            chk($sformatf("%s_last%0d", nm, i), out_last, (i == 7) ? 1 : 0);
            chk($sformatf("%s_re%0d", nm, i), out_re, ere[i]);
            chk($sformatf("%s_im%0d", nm, i), out_im, eim[i]);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
        chk({nm, "_done_valid"}, out_valid, 0);
        chk({nm, "_done_inready"}, in_ready, 1);
        chk({nm, "_done_busy"}, busy, 0);
    endtask

    task automatic set_impulse();
        for (int i = 0; i < 8; i++) begin
            fre[i] = (i == 0) ? 16'sd16384 : 16'sd0;
            fim[i] = 16'sd0;
            ere[i] = 16'sd2048;
            eim[i] = 16'sd0;
        end
    endtask

    initial begin
        #2;
        chk("rst_inready", in_ready, 1);
        chk("rst_outvalid", out_valid, 0);
        chk("rst_outlast", out_last, 0);
        chk("rst_outidx", out_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_twaddr", tw_addr, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Impulse at n=0
        set_impulse();
        send_frame(1'b0);
        wait_out("imp");
        recv_frame("imp");

        // DC with in_valid held high through CALC and 5 cycles of backpressure
        for (int i = 0; i < 8; i++) begin
            fre[i] = 16'sd8000;
            fim[i] = 16'sd0;
            ere[i] = (i == 0) ? 16'sd8000 : 16'sd0;
            eim[i] = 16'sd0;
        end
        hold_valid = 1'b1;
        send_frame(1'b0);
        wait_out("dc");
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_idx", out_idx, 0);
            chk("bp_re", out_re, 16'sd8000);
            chk("bp_im", out_im, 16'sd0);
            chk("bp_inready", in_ready, 0);
        end
        hold_valid = 1'b0;
        in_valid   = 1'b0;
        recv_frame("dc");

        // Alternating real sequence, forward then inverse
        for (int i = 0; i < 8; i++) begin
            fre[i] = (i % 2 == 0) ? 16'sd8000 : -16'sd8000;
            fim[i] = 16'sd0;
            ere[i] = (i == 4) ? 16'sd8000 : 16'sd0;
            eim[i] = 16'sd0;
        end
        send_frame(1'b0);
        wait_out("alt_fwd");
        recv_frame("alt_fwd");
        send_frame(1'b1);
        wait_out("alt_inv");
        recv_frame("alt_inv");

        // Impulse at n=1: exercises every twiddle, forward
        for (int i = 0; i < 8; i++) begin
            fre[i] = (i == 1) ? 16'sd16384 : 16'sd0;
            fim[i] = 16'sd0;
        end
        ere[0] = 16'sd2048;   eim[0] = 16'sd0;
        ere[1] = 16'sd1448;   eim[1] = -16'sd1449;
        ere[2] = 16'sd0;      eim[2] = -16'sd2048;
        ere[3] = -16'sd1449;  eim[3] = -16'sd1449;
        ere[4] = -16'sd2048;  eim[4] = 16'sd0;
        ere[5] = -16'sd1448;  eim[5] = 16'sd1448;
        ere[6] = 16'sd0;      eim[6] = 16'sd2048;
        ere[7] = 16'sd1448;   eim[7] = 16'sd1448;
        send_frame(1'b0);
        wait_out("shift_fwd");
        recv_frame("shift_fwd");

        // Same input with conjugate twiddles
        ere[0] = 16'sd2048;   eim[0] = 16'sd0;
        ere[1] = 16'sd1448;   eim[1] = 16'sd1448;
        ere[2] = 16'sd0;      eim[2] = 16'sd2047;
        ere[3] = -16'sd1449;  eim[3] = 16'sd1448;
        ere[4] = -16'sd2048;  eim[4] = 16'sd0;
        ere[5] = -16'sd1448;  eim[5] = -16'sd1448;
        ere[6] = 16'sd0;      eim[6] = -16'sd2048;
        ere[7] = 16'sd1448;   eim[7] = -16'sd1448;
        send_frame(1'b1);
        wait_out("shift_inv");
        recv_frame("shift_inv");

        // Reset four cycles into CALC, then a clean impulse frame
        set_impulse();
        send_frame(1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("midcalc_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        chk("midrst_inready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_outvalid", out_valid, 0);
        chk("midrst_twaddr", tw_addr, 0);
        chk("midrst_outidx", out_idx, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(1'b0);
        wait_out("imp2");
        recv_frame("imp2");

        // Most-negative input on both components
        for (int i = 0; i < 8; i++) begin
            fre[i] = -16'sd32768;
            fim[i] = -16'sd32768;
            ere[i] = (i == 0) ? -16'sd32768 : 16'sd0;
            eim[i] = (i == 0) ? -16'sd32768 : 16'sd0;
        end
        send_frame(1'b0);
        wait_out("sat");
        recv_frame("sat");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_iter_core.md
FFT_ITER_CORE -- requirements
Module: fft_iter_core

Interface
REQ-001 SHALL have parameter LOG2N, default 3, giving log2 of transform size N = 2^LOG2N; legal range 2..10.
REQ-002 SHALL have parameter DW, default 16, giving the signed two's-complement width of each sample component.
REQ-003 SHALL have parameter TW, default 16, giving the twiddle component width, signed Q1.(TW-1).
REQ-004 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_re (input, DW), in_im (input, DW): input sample stream.
REQ-007 SHALL have port inv, input, 1 bit: inverse-transform select, sampled with the first sample of each frame.
REQ-008 SHALL have ports tw_addr (output, LOG2N-1), tw_re (input, TW), tw_im (input, TW): combinational twiddle ROM port, W(k) = exp(-j2πk/N), k = tw_addr.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_re (output, DW), out_im (output, DW), out_idx (output, LOG2N), out_last (output, 1): result stream.
REQ-010 SHALL have port busy, output, 1 bit: high in CALC and UNLOAD.

Function
REQ-011 SHALL implement states LOAD, CALC, UNLOAD, holding N complex words in an internal register array.
REQ-012 In LOAD, in_ready SHALL be 1; each handshake (in_valid & in_ready) writes the sample at bit-reversed(load count); the count increments.
REQ-013 inv SHALL be latched on the handshake at load count 0 and held for the frame.
REQ-014 After the handshake at load count N-1, the block SHALL enter CALC on the next edge.
REQ-015 CALC SHALL perform exactly one radix-2 DIT butterfly per cycle: stages s = 0..LOG2N-1, half-span h = 2^s, top = g·2h + j, bottom = top + h, k = j << (LOG2N-1-s); N/2·LOG2N cycles in total.
REQ-016 tw_addr SHALL equal k during CALC and 0 otherwise; if the latched inv = 1, the block SHALL use -tw_im (conjugate twiddle).
REQ-017 When k = 0, the multiply SHALL be bypassed (t = b exactly); otherwise t_re = (b_re·w_re - b_im·w_im) >>> (TW-1), and t_im likewise, using full-precision products.
REQ-018 Outputs SHALL be top = sat((a + t) >>> 1) and bottom = sat((a - t) >>> 1), computed at DW+2 bits, with arithmetic shift (floor) and saturation to [-2^(DW-1), 2^(DW-1)-1].
REQ-019 As a result, the final output SHALL be X[k]/N in natural order.
REQ-020 After the last butterfly, the block SHALL enter UNLOAD; out_valid SHALL rise exactly N/2·LOG2N cycles after the edge of the last input handshake (12 for N=8).
REQ-021 In UNLOAD, out_re/out_im SHALL present word out_idx, and out_last SHALL equal (out_idx == N-1).
REQ-022 While out_valid & !out_ready, all out_* signals SHALL hold stable.
REQ-023 Each output handshake SHALL increment out_idx; after the handshake with out_last = 1, the block SHALL return to LOAD with out_valid = 0 and in_ready = 1 on the next cycle.
REQ-024 in_ready SHALL be 0 in CALC and UNLOAD; in_valid SHALL be ignored there, and out_ready SHALL be ignored outside UNLOAD.

Reset
REQ-025 On rst, the block SHALL go to LOAD immediately, from any state including mid-CALC or mid-UNLOAD, and discard the current frame.
REQ-026 Reset values SHALL be: in_ready = 1, out_valid = 0, out_last = 0, out_idx = 0, busy = 0, tw_addr = 0, load count = 0, latched inv = 0.
REQ-027 The contents of the sample array SHALL NOT be required to reset.
REQ-028 The first frame after rst deasserts SHALL be processed exactly as any other frame.

Verification (N=8, DW=16, TW=16, standard ROM round(32767·cos/sin))
REQ-029 Impulse: x0 = 16384+0j, x1..x7 = 0, inv = 0 -> all eight outputs = 2048+0j, out_idx 0..7, out_last only on idx 7.
REQ-030 DC: all x = 8000+0j -> bin 0 = 8000+0j; bins 1..7 = 0+0j exactly.
REQ-031 Alternating: x = +8000, -8000, ... real, with inv = 0 and again with inv = 1 -> bin 4 = 8000+0j, all other bins 0 in both runs.
REQ-032 Latency/backpressure: in_valid held 1 -> out_valid rises 12 cycles after the 8th handshake; with out_ready = 0 for 5 cycles, out_idx stays 0 and the data stays unchanged; in_ready stays 0 until the idx-7 handshake.
REQ-033 Reset mid-CALC: assert rst 4 cycles into CALC -> in_ready = 1, busy = 0, out_valid = 0 immediately; a following impulse frame yields REQ-029 results.
REQ-034 Saturation: all x = -32768-32768j -> bin 0 = -32768-32768j, bins 1..7 = 0, with no wrap-around.
